// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: walks a W-bit operation through an external combinational
// 4-bit adder/logic unit, one nibble per clock, least significant nibble first.
// The carry is chained between nibbles, and the result and C/Z flags are
// returned over a valid/ready handshake.
module alu_nibble_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [2:0]   op_code,
  output logic [3:0]   alu_op1,
  output logic [3:0]   alu_op2,
  output logic         alu_cin,
  output logic [1:0]   alu_s,
  output logic         alu_l,
  input  logic [3:0]   alu_out,
  input  logic         alu_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         flag_c,
  output logic         flag_z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_RSV = 3'b011;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  state_t       state;
  logic [2:0]   idx;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   op_q;
  logic         carry;

  logic         rsv_op;
  logic         arith_op;
  logic         last_nib;
  logic [3:0]   a_nib;
  logic [3:0]   b_nib;
  logic [3:0]   wr_nib;
  logic [W-1:0] res_next;

  // Select nibble n of a word (n counts from the least significant nibble).
  function automatic logic [3:0] nib_sel(input logic [W-1:0] word, input logic [2:0] n);
    return 4'(word >> {n, 2'b00});
  endfunction

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);

  assign rsv_op   = (op_q == OP_RSV);
  assign arith_op = !op_q[2] && !rsv_op;
  assign last_nib = (idx == LAST_IDX);
  assign a_nib    = nib_sel(a_q, idx);
  assign b_nib    = nib_sel(b_q, idx);
  // The reserved opcode leaves the unit idle and writes zero nibbles.
  assign wr_nib   = rsv_op ? 4'h0 : alu_out;

  // Drive the unit from the latched request; everything idles outside RUN.
  always_comb begin
    alu_op1 = 4'h0;
    alu_op2 = 4'h0;
    alu_cin = 1'b0;
    alu_s   = 2'b00;
    alu_l   = 1'b0;
    if (state == RUN && !rsv_op) begin
      alu_op1 = a_nib;
      alu_op2 = (op_q == OP_SUB) ? ~b_nib : b_nib;
      if (op_q[2]) begin
        alu_l = 1'b1;
        alu_s = op_q[1:0];
      end else begin
        alu_cin = carry;
      end
    end
  end

  // Result word with the current nibble merged in, so Z sees the final nibble.
  always_comb begin
    res_next = result;
    res_next[{idx, 2'b00} +: 4] = wr_nib;
  end

  // Sequencer FSM: accept, run one nibble per clock, hold result until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= 3'd0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 3'd0;
      carry  <= 1'b0;
      result <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            op_q  <= op_code;
            idx   <= 3'd0;
            state <= RUN;
            case (op_code)
              OP_ADC:  carry <= flag_c;
              OP_SUB:  carry <= 1'b1;
              OP_ADD:  carry <= 1'b0;
              default: carry <= 1'b0;
            endcase
          end
        end
        RUN: begin
          result <= res_next;
          if (arith_op) carry <= alu_cout;
          if (last_nib) begin
            state  <= DONE;
            idx    <= 3'd0;
            flag_z <= (res_next == '0);
            if (arith_op) flag_c <= alu_cout;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq with a behavioural model of the 4-bit
// adder/logic unit attached to the alu_* ports (NIBBLES = 4).
module tb_alu_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   op_code;
  logic [3:0]   alu_op1;
  logic [3:0]   alu_op2;
  logic         alu_cin;
  logic [1:0]   alu_s;
  logic         alu_l;
  logic [3:0]   alu_out;
  logic         alu_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         flag_c;
  logic         flag_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_code   (op_code),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_l     (alu_l),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  // Model of the 4-bit adder/logic unit.
  always_comb begin
    logic [4:0] sum;
    sum      = {1'b0, alu_op1} + {1'b0, alu_op2} + {4'b0, alu_cin};
    alu_out  = sum[3:0];
    alu_cout = sum[4];
    if (alu_l) begin
      alu_cout = 1'b0;
      case (alu_s)
        2'b00:   alu_out = alu_op1 & alu_op2;
        2'b01:   alu_out = alu_op1 | alu_op2;
        2'b10:   alu_out = alu_op1 ^ alu_op2;
        default: alu_out = ~alu_op1;
      endcase
    end
  end

  typedef struct {
    logic [2:0]   opc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_c;
    logic         exp_z;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for res_valid; records latency
  // and the alu_cin value seen in each RUN cycle.
  task automatic run_op(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [3:0] cins);
    @(negedge clk);
    in_valid = 1'b1;
    op_code  = opc;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    cins     = 4'b0;
    cins[0]  = alu_cin;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!res_valid && lat < 4) cins[lat] = alu_cin;
    end
  endtask

  initial begin
    int         lat;
    logic [3:0] cins;

    vecs[0]  = '{3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[2]  = '{3'b001, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{3'b110, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b1, 1'b0};
    vecs[6]  = '{3'b111, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{3'b100, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0};
    vecs[8]  = '{3'b101, 16'h1200, 16'h0034, 16'h1234, 1'b1, 1'b0};
    vecs[9]  = '{3'b011, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1};
    vecs[12] = '{3'b001, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_code   = 3'b000;
    res_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({flag_c, flag_z}), 32'd0);
    check("rst_alu_idle", 32'({alu_op1, alu_op2, alu_cin, alu_s, alu_l}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table; flag_c carries from one vector to the next.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].opc, vecs[i].a, vecs[i].b, lat, cins);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      check($sformatf("v%0d_flag_c", i), 32'(flag_c), 32'(vecs[i].exp_c));
      check($sformatf("v%0d_flag_z", i), 32'(flag_z), 32'(vecs[i].exp_z));
      if (i == 0) check("v0_cin_seq", 32'(cins), 32'b0110);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_back_idle", i), 32'({in_ready, res_valid}), 32'b10);
    end

    // Backpressure: hold DONE while pulsing in_valid.
    res_ready = 1'b0;
    run_op(3'b000, 16'h0001, 16'h0002, lat, cins);
    check("bp_result0", 32'(result), 32'h0003);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_code  = 3'b111;
      op_a     = 16'h0F0F;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_hold", k), 32'({res_valid, in_ready}), 32'b10);
      check($sformatf("bp%0d_result", k), 32'(result), 32'h0003);
      check($sformatf("bp%0d_flags", k), 32'({flag_c, flag_z}), 32'b00);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", 32'({in_ready, res_valid}), 32'b10);
    check("bp_result_kept", 32'(result), 32'h0003);
    @(posedge clk);
    #1;
    check("bp_not_accepted", 32'({in_ready, res_valid}), 32'b10);

    // Set flag_c first so the mid-RUN reset visibly clears it.
    run_op(3'b000, 16'hFFFF, 16'h0001, lat, cins);
    check("pre_rst_flag_c", 32'(flag_c), 32'd1);
    @(posedge clk);

    // Reset during RUN cycle idx 2.
    @(negedge clk);
    in_valid = 1'b1;
    op_code  = 3'b000;
    op_a     = 16'h1234;
    op_b     = 16'h1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_flags", 32'({flag_c, flag_z}), 32'd0);
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (res_valid) seen++;
      end
      check("mid_rst_no_valid", 32'(seen), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3'b000, 16'h1234, 16'h1111, lat, cins);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_result", 32'(result), 32'h2345);
    check("post_rst_flags", 32'({flag_c, flag_z}), 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
Multi-cycle sequencer that runs N-nibble (default 16-bit) arithmetic and logic operations through the team's combinational 4-bit adder/logic unit (sum4_ul4), one nibble per clock.
It accepts operand/opcode requests over a valid/ready handshake and drives the unit's OP1/OP2/c_in/S/L inputs, least significant nibble first.
It captures Out/c_out into a result register, chaining the carry between nibbles.
It returns the full-width result plus C and Z flags over a second valid/ready handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; word width W = 4*NIBBLES; legal range 1..8.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  sequencer can accept a request.
op_a  in  W  operand A.
op_b  in  W  operand B.
op_code  in  3  000 ADD, 001 ADC, 010 SUB, 011 reserved, 100 AND, 101 OR, 110 XOR, 111 NOT A.
alu_op1  out  4  to unit OP1.
alu_op2  out  4  to unit OP2.
alu_cin  out  1  to unit c_in.
alu_s  out  2  to unit S.
alu_l  out  1  to unit L (0 = arithmetic, 1 = logic).
alu_out  in  4  from unit Out.
alu_cout  in  1  from unit c_out.
res_valid  out  1  result valid.
res_ready  in  1  consumer accepts result.
result  out  W  result word.
flag_c  out  1  stored carry flag.
flag_z  out  1  result == 0.

Behaviour:
- FSM states: IDLE, RUN, DONE. in_ready = (state == IDLE); res_valid = (state == DONE). Both are decoded from registered state.
- Reset (async assert, any state):
  - state IDLE, nibble index 0, result 0, flag_c 0, flag_z 0, latched operands/opcode 0.
  - During reset: in_ready 1, res_valid 0.
  - Reset mid-RUN or mid-DONE aborts the operation; no res_valid is produced.
- IDLE:
  - On in_valid at a clock edge: latch op_a, op_b, op_code; set idx = 0; set running carry (see below); go to RUN.
  - alu_* outputs are driven 0 in IDLE.
- RUN (cycle idx):
  - alu_op1 = A[4*idx+3:4*idx].
  - alu_op2 = B nibble, bitwise inverted for SUB.
  - Arithmetic ops: alu_l = 0, alu_s = 00, alu_cin = running carry.
  - Logic ops: alu_l = 1, alu_s = op_code[1:0], alu_cin = 0.
  - At each edge: result nibble idx <= alu_out; for arithmetic ops, running carry <= alu_cout; idx increments.
  - alu_cout is ignored for logic ops.
  - After the edge that writes nibble NIBBLES-1, go to DONE.
- Initial running carry: ADD 0, ADC = flag_c, SUB 1.
- SUB computes A + ~B + 1; flag_c = 1 means no borrow.
- Reserved opcode 011:
  - Takes the same RUN length with the unit driven as in IDLE.
  - Result is written 0, so flag_z = 1; flag_c unchanged.
- Flags, updated on the DONE-entry edge:
  - flag_c <= final carry for ADD/ADC/SUB; unchanged for logic ops and 011.
  - flag_z <= (final result == 0), evaluated including the last nibble written on that edge.
- DONE:
  - result and flags are held stable while res_ready = 0.
  - On res_ready at a clock edge, go to IDLE.
  - in_valid is ignored while not in IDLE; there is no IDLE bypass.
- Latency and throughput:
  - Request accepted at edge T; res_valid first high after edge T+NIBBLES.
  - Back-to-back requests are spaced at minimum NIBBLES+2 cycles.
- result is not cleared between operations; only nibbles of the running operation are overwritten.
- Width rules:
  - All additions are modulo 2^W; carry out of the top nibble goes only to flag_c.
  - Nibble ordering is LSB nibble first.

Test Plan:
Bench connects the team's 4-bit adder/logic unit to the alu_* ports; NIBBLES = 4.
1. Reset, then ADD 0x00FF + 0x0001 accepted at edge T -> res_valid rises after edge T+4, result 0x0100, flag_c 0, flag_z 0; alu_cin sequence 0,1,1,0.
2. ADD 0xFFFF + 0x0001 -> result 0x0000, flag_c 1, flag_z 1. Then ADC 0x0000 + 0x0000 -> result 0x0001, flag_c 0, flag_z 0.
3. SUB 0x0005 - 0x0007 -> result 0xFFFE, flag_c 0. SUB 0x0007 - 0x0005 -> result 0x0002, flag_c 1.
4. With flag_c = 1 set first, XOR 0xA5A5 ^ 0xFFFF -> result 0x5A5A, flag_c stays 1. NOT A 0xFFFF -> result 0x0000, flag_z 1.
5. Backpressure: hold res_ready 0 for 3 cycles in DONE while pulsing in_valid -> result and flags stable, in_ready 0, request not accepted; release -> IDLE next edge.
6. Assert reset_n low during RUN cycle idx 2 -> immediately state IDLE, in_ready 1, result 0, flags 0, no res_valid; a fresh ADD 0x1234 + 0x1111 -> result 0x2345.
